// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for serial_subtractor.
// With SERIAL_SUBTRACTOR_ZERO_FLAG_EN defined the bundle also carries a
// registered zero flag for the most recent result.
interface serial_subtractor_if #(
    parameter int W = 4
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    logic         zero;

    modport master (output start, output a, output b,
                    input busy, input done, input diff, input borrow_out, input zero);
    modport slave  (input start, input a, input b,
                    output busy, output done, output diff, output borrow_out, output zero);
`else
    modport master (output start, output a, output b,
                    input busy, input done, input diff, input borrow_out);
    modport slave  (input start, input a, input b,
                    output busy, output done, output diff, output borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: computes a - b LSB first, one bit per clock,
// chaining a full-subtractor cell through a registered borrow flip-flop.
// The result and final borrow update only when the last bit is processed
// and hold their value until the next result replaces them.
// Optional macro SERIAL_SUBTRACTOR_ZERO_FLAG_EN adds a registered zero flag.
module serial_subtractor #(
    parameter int W = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [W-1:0]  a_sh_r;
    logic [W-1:0]  b_sh_r;
    logic [W-1:0]  acc_r;
    logic [W-1:0]  acc_next_s;
    logic [W-1:0]  diff_r;
    logic [CW-1:0] count_r;
    logic          borrow_r;
    logic          borrow_out_r;
    logic          d_s;
    logic          br_next_s;
    logic          last_s;
    logic          busy_s;
    logic          done_s;

    // Full-subtractor difference bit.
    function automatic logic sub_diff(input logic ai, input logic bi, input logic br);
        return ai ^ bi ^ br;
    endfunction

    // Full-subtractor borrow out of the current bit position.
    function automatic logic sub_borrow(input logic ai, input logic bi, input logic br);
        return (~ai & bi) | (~(ai ^ bi) & br);
    endfunction

    // Bit cell on the current LSBs plus the accumulator with the new bit at its MSB.
    always_comb begin
        d_s            = sub_diff(a_sh_r[0], b_sh_r[0], borrow_r);
        br_next_s      = sub_borrow(a_sh_r[0], b_sh_r[0], borrow_r);
        acc_next_s     = acc_r >> 1;
        acc_next_s[W-1] = d_s;
        last_s         = (count_r == CW'(W - 1));
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: start is only honoured from IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Status decode straight from the state register.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            SHIFT: begin
                busy_s = 1'b1;
                done_s = 1'b0;
            end
            DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Operand shifting, borrow chaining and result capture on the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r       <= {W{1'b0}};
            b_sh_r       <= {W{1'b0}};
            acc_r        <= {W{1'b0}};
            count_r      <= {CW{1'b0}};
            borrow_r     <= 1'b0;
            diff_r       <= {W{1'b0}};
            borrow_out_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        a_sh_r   <= bus.a;
                        b_sh_r   <= bus.b;
                        acc_r    <= {W{1'b0}};
                        count_r  <= {CW{1'b0}};
                        borrow_r <= 1'b0;
                    end else begin
                        count_r  <= count_r;
                    end
                end
                SHIFT: begin
                    a_sh_r   <= a_sh_r >> 1;
                    b_sh_r   <= b_sh_r >> 1;
                    acc_r    <= acc_next_s;
                    borrow_r <= br_next_s;
                    count_r  <= count_r + CW'(1);
                    if (last_s) begin
                        diff_r       <= acc_next_s;
                        borrow_out_r <= br_next_s;
                    end else begin
                        diff_r       <= diff_r;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    logic zero_r;

    // Zero flag follows the result register, updated only with a new result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_r <= 1'b0;
        end else if ((state_r == SHIFT) && last_s) begin
            zero_r <= (acc_next_s == {W{1'b0}});
        end else begin
            zero_r <= zero_r;
        end
    end

    assign bus.zero = zero_r;
`endif

    assign bus.busy       = busy_s;
    assign bus.done       = done_s;
    assign bus.diff       = diff_r;
    assign bus.borrow_out = borrow_out_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (W=4 and W=1 instances).
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;

    serial_subtractor_if #(.W(4)) bus4 ();
    serial_subtractor_if #(.W(1)) bus1 ();

    serial_subtractor #(.W(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    serial_subtractor #(.W(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one W=4 operation; return edges to done and whether diff held prev meanwhile.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] prev,
                        output int lat, output logic held);
        bus4.a     = a;
        bus4.b     = b;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        bus4.a     = ~a;
        bus4.b     = ~b;
        lat  = 0;
        held = 1'b1;
        while (bus4.done !== 1'b1 && lat < 20) begin
            if (bus4.diff !== prev) held = 1'b0;
            tick();
            lat++;
        end
    endtask

    int         lat;
    logic       held;
    int         busy_n;
    int         done_at;
    int         pulses;
    logic [3:0] cap_diff;
    logic       cap_bo;
    logic [3:0] exp_d1;
    logic [3:0] exp_b1;
    logic [1:0] ab;
    logic [9:0] mask;

    initial begin
        // Reset with start asserted: reset must win.
        rst = 1'b1;
        bus4.start = 1'b1; bus4.a = 4'd9; bus4.b = 4'd3;
        bus1.start = 1'b1; bus1.a = 1'b1; bus1.b = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(bus4.busy), 32'd0);
        chk("rst_done", 32'(bus4.done), 32'd0);
        chk("rst_diff", 32'(bus4.diff), 32'd0);
        chk("rst_borrow", 32'(bus4.borrow_out), 32'd0);
        chk("rst_busy_w1", 32'(bus1.busy), 32'd0);
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
        chk("rst_zero", 32'(bus4.zero), 32'd0);
`endif
        bus4.start = 1'b0;
        bus1.start = 1'b0;
        rst = 1'b0;
        tick();

        // 9 - 3: timing of busy/done and the result.
        bus4.a = 4'd9; bus4.b = 4'd3; bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0; bus4.a = 4'd0; bus4.b = 4'd15;
        busy_n = 0; done_at = -1; pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus4.busy === 1'b1) busy_n++;
            if (bus4.done === 1'b1) begin
                pulses++;
                done_at = i;
            end
            if (i < 4) chk("hold_zero_before_done", 32'(bus4.diff), 32'd0);
            tick();
        end
        chk("op1_busy_cycles", 32'(busy_n), 32'd5);
        chk("op1_done_edge", 32'(done_at), 32'd4);
        chk("op1_done_pulses", 32'(pulses), 32'd1);
        chk("op1_diff", 32'(bus4.diff), 32'h6);
        chk("op1_borrow", 32'(bus4.borrow_out), 32'd0);
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
        chk("op1_zero", 32'(bus4.zero), 32'd0);
`endif

        // 3 - 9 wraps with borrow.
        run4(4'd3, 4'd9, 4'd6, lat, held);
        chk("op2_latency", 32'(lat), 32'd4);
        chk("op2_held", 32'(held), 32'd1);
        chk("op2_diff", 32'(bus4.diff), 32'hA);
        chk("op2_borrow", 32'(bus4.borrow_out), 32'd1);
        tick();

        // 0 - 15: previous result 1010 must hold until the result edge.
        run4(4'd0, 4'd15, 4'hA, lat, held);
        chk("op3_latency", 32'(lat), 32'd4);
        chk("op3_held_prev", 32'(held), 32'd1);
        chk("op3_diff", 32'(bus4.diff), 32'h1);
        chk("op3_borrow", 32'(bus4.borrow_out), 32'd1);
        tick();

        // a == b gives zero with no borrow.
        run4(4'd5, 4'd5, 4'h1, lat, held);
        chk("op_eq_diff", 32'(bus4.diff), 32'h0);
        chk("op_eq_borrow", 32'(bus4.borrow_out), 32'd0);
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
        chk("op_eq_zero", 32'(bus4.zero), 32'd1);
`endif
        tick();

        // Second start while busy is ignored: 12 - 5 = 7, one done pulse.
        bus4.a = 4'd12; bus4.b = 4'd5; bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        tick();
        tick();
        bus4.a = 4'd1; bus4.b = 4'd2; bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        pulses = 0; cap_diff = 4'hF; cap_bo = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus4.done === 1'b1) begin
                pulses++;
                cap_diff = bus4.diff;
                cap_bo   = bus4.borrow_out;
            end
            tick();
        end
        chk("ign_pulses", 32'(pulses), 32'd1);
        chk("ign_diff", 32'(cap_diff), 32'h7);
        chk("ign_borrow", 32'(cap_bo), 32'd0);

        // Asynchronous reset after two bits of 13 - 4.
        bus4.a = 4'd13; bus4.b = 4'd4; bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus4.busy), 32'd0);
        chk("arst_done", 32'(bus4.done), 32'd0);
        chk("arst_diff", 32'(bus4.diff), 32'd0);
        chk("arst_borrow", 32'(bus4.borrow_out), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_idle_after", 32'(bus4.busy), 32'd0);
        run4(4'd7, 4'd2, 4'd0, lat, held);
        chk("post_rst_latency", 32'(lat), 32'd4);
        chk("post_rst_diff", 32'(bus4.diff), 32'h5);
        chk("post_rst_borrow", 32'(bus4.borrow_out), 32'd0);
        tick();

        // W=1: all four operand combinations, indexed by {a,b}.
        exp_d1 = 4'b0110;
        exp_b1 = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            bus1.a = ab[1];
            bus1.b = ab[0];
            bus1.start = 1'b1;
            tick();
            bus1.start = 1'b0;
            chk("w1_busy", 32'(bus1.busy), 32'd1);
            tick();
            chk("w1_done", 32'(bus1.done), 32'd1);
            chk("w1_diff", 32'(bus1.diff), 32'(exp_d1[i]));
            chk("w1_borrow", 32'(bus1.borrow_out), 32'(exp_b1[i]));
            tick();
            chk("w1_done_drop", 32'(bus1.done), 32'd0);
        end

        // W=1 with start held high: a done pulse every three cycles.
        bus1.a = 1'b1; bus1.b = 1'b0; bus1.start = 1'b1;
        mask = 10'd0;
        for (int t = 1; t < 10; t++) begin
            tick();
            mask[t] = bus1.done;
        end
        bus1.start = 1'b0;
        chk("w1_b2b_mask", 32'(mask), 32'h124);
        chk("w1_b2b_diff", 32'(bus1.diff), 32'd1);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial W-bit subtractor computing a - b, LSB first, one bit per clock.
- Built around a half/full-subtractor bit cell and a registered borrow flip-flop.
- Sits directly downstream of the combinational half-subtractor stage: it chains that cell's diff/borrow terms across cycles to produce a full-width difference and final borrow.
- Start/done handshake; the result stays stable between operations.

Parameters:
- W, 4, operand and result width in bits; legal range W >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  W  minuend; sampled on the accepted start edge
- b  input  W  subtrahend; sampled on the accepted start edge
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse: result just updated
- diff  output  W  result register, a - b mod 2^W
- borrow_out  output  1  final borrow: 1 iff a < b unsigned

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - While rst is high: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, borrow FF=0, counter=0.
  - Also clears the internal shift registers.
  - Reset mid-operation aborts the operation; no partial result is written.
- State machine: IDLE, SHIFT, DONE.
  - IDLE:
    - start=1 at an edge: latch a and b into shift registers, clear the borrow FF, set count=0, go to SHIFT.
    - start=0: stay in IDLE.
  - SHIFT, one bit per edge:
    - ai, bi = current LSBs of the shift registers; br = borrow FF.
    - d = ai ^ bi ^ br.
    - br_next = (~ai & bi) | (~(ai ^ bi) & br).
    - Shift both operand registers right by one.
    - Shift d into the MSB of the internal accumulator.
    - count increments.
    - On the edge that processes bit W-1: copy the accumulator to diff, br_next to borrow_out, go to DONE.
  - DONE: done=1 for exactly this one cycle; the next edge returns to IDLE unconditionally.
- Latency:
  - Start accepted at edge 0.
  - Bits processed at edges 1..W.
  - diff, borrow_out and done valid in the cycle after edge W.
  - Next start accepted at edge W+1 at the earliest.
  - Throughput: one operation per W+2 cycles.
- Handshake:
  - start is ignored while busy=1 (SHIFT or DONE); no queuing.
  - a and b may change freely after the accepted start edge.
  - start may be held high continuously; it is re-accepted on each return to IDLE.
- Outputs:
  - diff and borrow_out change only on the SHIFT->DONE edge (or on reset).
  - They hold the previous result throughout a new operation.
- Arithmetic: unsigned, modulo 2^W; wrap-around result plus borrow_out=1 when a < b.
- Counter: width $clog2(W+1); W=1 must still work (single SHIFT cycle).
- Boundaries:
  - a=b gives diff=0, borrow_out=0.
  - a=0, b=2^W-1 gives diff=1, borrow_out=1.
  - start and rst asserted together: rst wins.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_ZERO_FLAG_EN.
- Defined:
  - Extra output port zero (1 bit), registered.
  - Updated on the SHIFT->DONE edge to 1 iff the new diff == 0.
  - Reset value 0; held between operations like diff.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- W=4, a=9, b=3, start pulse -> done high exactly 5 cycles after the start edge (one cycle after edge W=4); diff=4'b0110, borrow_out=0; busy high for 5 cycles.
- W=4, a=3, b=9 -> diff=4'b1010, borrow_out=1. With the macro: a=5, b=5 -> diff=0, borrow_out=0, zero=1.
- W=4, a=0, b=15 -> diff=4'b0001, borrow_out=1. diff keeps the previous result (4'b1010) during the whole operation until the DONE edge.
- W=4, start pulsed again 2 cycles into an operation with different a/b -> ignored; the result matches the first operands; exactly one done pulse.
- W=4, rst asserted asynchronously mid-edge during SHIFT (after 2 bits) -> immediately busy=0, done=0, diff=0, borrow_out=0. After release, a fresh start with a=7, b=2 gives diff=5, borrow_out=0.
- W=1, all four a/b combinations -> diff/borrow_out = 00,11,10,00 for ab=00,01,10,11; done 2 cycles after each start. start held high continuously gives back-to-back operations every 3 cycles.
